// File: rtl/inst_fetch_if.sv
// Instruction bus between the IF stage and the instruction memory port.
// Request side: inst_req/inst_addr. Response side: addr_ok accept, data_ok read data.
// A single request is outstanding at a time; responses return in order.
interface inst_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // Fetch stage drives the request and consumes the response
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  // Memory side accepts the request and returns the data
  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, fetches one word per instruction over the req/addr_ok/data_ok bus.
// Latency: at least 3 cycles per instruction (request accepted, data returned, one HOLD cycle).
// Backpressure: stall[0] holds the presented instruction in HOLD; stallreq_o=1 while no fetch is complete.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  input  logic          branch_flag,
  input  logic [31:0]   branch_target,
  output logic          stallreq_o,
  inst_fetch_if.master  bus,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_inst,
  output logic          if_excepttype_o
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pend_br_vld;
  logic [31:0] pend_br_tgt;

  logic        pc_aligned;
  logic        advance;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Only stall[0] concerns the fetch stage; the upper bits belong to later stages.
  logic        unused_stall_hi;
  assign unused_stall_hi = ^stall[5:1];

  // A misaligned PC never reaches the bus; it is reported as an address error instead.
  assign pc_aligned    = (pc[1:0] == 2'b00);
  assign bus.inst_req  = (state == S_REQ) && pc_aligned;
  assign bus.inst_addr = pc;

  // Only HOLD presents a completed fetch to the IF/ID register.
  assign stallreq_o = (state != S_HOLD);

  // The PC moves forward only when the held instruction is consumed downstream.
  assign advance  = (state == S_HOLD) && !stall[0];
  assign pc_plus4 = pc + 32'd4;

  // Redirect priority at advance: a branch resolved this cycle, then a remembered one, then sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (branch_flag) begin
      next_pc = branch_target;
    end else if (pend_br_vld) begin
      next_pc = pend_br_tgt;
    end
  end

  // Fetch FSM, PC, pending branch and presented instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_REQ;
      pc              <= RESET_PC;
      pend_br_vld     <= 1'b0;
      pend_br_tgt     <= 32'd0;
      if_pc           <= 32'd0;
      if_inst         <= 32'd0;
      if_excepttype_o <= 1'b0;
    end else if (flush) begin
      pc <= flush_pc;
      if (state == S_DISCARD) begin
        // Still owe the bus one response; only the restart address changes.
        if (bus.inst_data_ok) begin
          state <= S_REQ;
        end
      end else begin
        pend_br_vld     <= 1'b0;
        if_inst         <= 32'd0;
        if_excepttype_o <= 1'b0;
        case (state)
          S_WAIT: begin
            // A response arriving with the flush is dropped on the spot.
            state <= bus.inst_data_ok ? S_REQ : S_DISCARD;
          end
          S_REQ: begin
            // A request accepted this very cycle leaves a response to throw away.
            state <= (bus.inst_req && bus.inst_addr_ok) ? S_DISCARD : S_REQ;
          end
          default: begin
            state <= S_REQ;
          end
        endcase
      end
    end else begin
      // A branch that cannot redirect immediately is remembered; newer overwrites older.
      if (branch_flag && !advance) begin
        pend_br_vld <= 1'b1;
        pend_br_tgt <= branch_target;
      end

      case (state)
        S_REQ: begin
          if (!pc_aligned) begin
            state           <= S_HOLD;
            if_pc           <= pc;
            if_inst         <= 32'd0;
            if_excepttype_o <= 1'b1;
          end else if (bus.inst_addr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            state           <= S_HOLD;
            if_pc           <= pc;
            if_inst         <= bus.inst_rdata;
            if_excepttype_o <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall[0]) begin
            state           <= S_REQ;
            pc              <= next_pc;
            pend_br_vld     <= 1'b0;
            // Clearing here keeps if_inst a bubble everywhere outside HOLD.
            if_inst         <= 32'd0;
            if_excepttype_o <= 1'b0;
          end
        end
        default: begin
          if (bus.inst_data_ok) begin
            state <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a scoreboard of expected presented instructions.
// Each completed fetch queues its expected (pc, inst, excepttype); a monitor pops on HOLD entry.
// Also watches that a dropped word never appears on if_inst.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        stallreq_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_excepttype_o;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'hBFC00000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .branch_flag     (branch_flag),
    .branch_target   (branch_target),
    .stallreq_o      (stallreq_o),
    .bus             (bus.master),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_excepttype_o (if_excepttype_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic in_hold  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address and accept it in the same cycle.
  task automatic accept_req(input string tag, input logic [31:0] addr);
    int k;
    k = 0;
    while (bus.inst_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req"}, {31'd0, bus.inst_req}, 32'd1);
    chk({tag, "_addr"}, bus.inst_addr, addr);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
  endtask

  // Return one read word and record what the stage should present for it.
  task automatic give_data(input logic [31:0] d, input logic [31:0] pc_v);
    exp_t e;
    e.pc   = pc_v;
    e.inst = d;
    e.exc  = 1'b0;
    sb.push_back(e);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = d;
    tick();
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;
  endtask

  // Monitor: compare each newly presented instruction with the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      in_hold = 1'b0;
    end else begin
      chk("no_dropped_word", {31'd0, (if_inst !== 32'hDEADBEEF)}, 32'd1);
      if (!stallreq_o && !in_hold) begin
        in_hold = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_unexpected_hold", if_pc, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", if_pc, e.pc);
          chk("sb_inst", if_inst, e.inst);
          chk("sb_exc", {31'd0, if_excepttype_o}, {31'd0, e.exc});
        end
      end else if (stallreq_o) begin
        in_hold = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    rst              = 1'b1;
    stall            = 6'd0;
    flush            = 1'b0;
    flush_pc         = 32'd0;
    branch_flag      = 1'b0;
    branch_target    = 32'd0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_stallreq", {31'd0, stallreq_o}, 32'd1);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_exc", {31'd0, if_excepttype_o}, 32'd0);
    rst = 1'b0;
    chk("rst_addr", bus.inst_addr, 32'hBFC00000);

    // 1: first fetch, addr_ok immediately, data one cycle later
    accept_req("t1", 32'hBFC00000);
    chk("t1_wait_noreq", {31'd0, bus.inst_req}, 32'd0);
    give_data(32'h24010001, 32'hBFC00000);
    chk("t1_hold_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("t1_if_pc", if_pc, 32'hBFC00000);
    chk("t1_if_inst", if_inst, 32'h24010001);
    tick();
    chk("t1_next_addr", bus.inst_addr, 32'hBFC00004);

    // 2: hold for 5 cycles under stall[0]
    accept_req("t2", 32'hBFC00004);
    stall = 6'b000001;
    give_data(32'h3C02BFC0, 32'hBFC00004);
    held_pc   = if_pc;
    held_inst = if_inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_noreq", {31'd0, bus.inst_req}, 32'd0);
      chk("t2_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("t2_pc_held", if_pc, held_pc);
      chk("t2_inst_held", if_inst, held_inst);
    end
    stall = 6'd0;
    tick();
    chk("t2_next_addr", bus.inst_addr, 32'hBFC00008);

    // 3: flush while waiting; the late word is dropped
    accept_req("t3", 32'hBFC00008);
    flush    = 1'b1;
    flush_pc = 32'hBFC00380;
    tick();
    flush = 1'b0;
    chk("t3_discard_stallreq", {31'd0, stallreq_o}, 32'd1);
    chk("t3_discard_noreq", {31'd0, bus.inst_req}, 32'd0);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEADBEEF;
    tick();
    bus.inst_data_ok = 1'b0;
    chk("t3_restart_req", {31'd0, bus.inst_req}, 32'd1);
    chk("t3_restart_addr", bus.inst_addr, 32'hBFC00380);

    // 3b: flush together with data_ok in WAIT drops the word and restarts at once
    accept_req("t3b", 32'hBFC00380);
    flush            = 1'b1;
    flush_pc         = 32'hBFC00400;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEADBEEF;
    tick();
    flush            = 1'b0;
    bus.inst_data_ok = 1'b0;
    chk("t3b_req", {31'd0, bus.inst_req}, 32'd1);
    chk("t3b_addr", bus.inst_addr, 32'hBFC00400);

    // 4: branch in WAIT is remembered (newest wins) and taken at the next advance
    accept_req("t4", 32'hBFC00400);
    branch_flag   = 1'b1;
    branch_target = 32'h80000F00;
    tick();
    branch_target = 32'h80001000;
    tick();
    branch_flag = 1'b0;
    give_data(32'h8C220000, 32'hBFC00400);
    tick();
    chk("t4_pend_addr", bus.inst_addr, 32'h80001000);
    // branch during an advancing HOLD redirects directly
    accept_req("t4b", 32'h80001000);
    give_data(32'h10000003, 32'h80001000);
    branch_flag   = 1'b1;
    branch_target = 32'h80002000;
    tick();
    branch_flag = 1'b0;
    chk("t4b_direct_addr", bus.inst_addr, 32'h80002000);

    // 5: misaligned flush target raises the address error without a request
    flush    = 1'b1;
    flush_pc = 32'h80000002;
    e.pc   = 32'h80000002;
    e.inst = 32'd0;
    e.exc  = 1'b1;
    sb.push_back(e);
    tick();
    flush = 1'b0;
    chk("t5_noreq", {31'd0, bus.inst_req}, 32'd0);
    tick();
    chk("t5_exc", {31'd0, if_excepttype_o}, 32'd1);
    chk("t5_if_inst", if_inst, 32'd0);
    chk("t5_if_pc", if_pc, 32'h80000002);
    chk("t5_stallreq", {31'd0, stallreq_o}, 32'd0);

    // 6: PC wraps from FFFFFFFC to 0
    flush    = 1'b1;
    flush_pc = 32'hFFFFFFFC;
    tick();
    flush = 1'b0;
    chk("t6_exc_cleared", {31'd0, if_excepttype_o}, 32'd0);
    accept_req("t6", 32'hFFFFFFFC);
    give_data(32'h24420001, 32'hFFFFFFFC);
    tick();
    chk("t6_wrap_addr", bus.inst_addr, 32'h00000000);

    // 6b: reset during WAIT (with a branch pending) returns to the reset PC
    accept_req("t6b", 32'h00000000);
    branch_flag   = 1'b1;
    branch_target = 32'h80005000;
    tick();
    branch_flag = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6b_stallreq", {31'd0, stallreq_o}, 32'd1);
    chk("t6b_req", {31'd0, bus.inst_req}, 32'd1);
    chk("t6b_addr", bus.inst_addr, 32'hBFC00000);
    chk("t6b_if_pc", if_pc, 32'd0);
    chk("t6b_if_inst", if_inst, 32'd0);
    accept_req("t6c", 32'hBFC00000);
    give_data(32'h11111111, 32'hBFC00000);
    tick();
    chk("t6c_no_stale_branch", bus.inst_addr, 32'hBFC00004);

    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
